ptw_mem_arbiter: RTL

Shares one memory read port between the IFU-side and LSU-side MMU page-table walkers. Each walker issues a level request (address held until the response arrives). The arbiter grants requests round-robin, keeps at most one transaction outstanding, and returns the PTE word to the owning walker. It sits between the two `mmu` instances (`mmu_mem_*` signals) and the memory/cache port. It also handles MMU flush (`sfence.vma`) and a response watchdog.

---
 rtl/ptw_mem_arbiter_if.sv | 40 ++++
 rtl/ptw_mem_arbiter.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/ptw_mem_arbiter_if.sv
// Signal bundle between the two MMU walkers, the flush source and the shared memory read port.
// The arbiter takes the slave view; the walkers and memory together form the master side.
interface ptw_mem_arbiter_if;
   logic        flush_i;
   logic        if_req_i;
   logic [31:0] if_addr_i;
   logic        if_rvalid_o;
   logic [31:0] if_rdata_o;
   logic        if_err_o;
   logic        ls_req_i;
   logic [31:0] ls_addr_i;
   logic        ls_rvalid_o;
   logic [31:0] ls_rdata_o;
   logic        ls_err_o;
   logic        mem_req_o;
   logic [31:0] mem_addr_o;
   logic        mem_ready_i;
   logic        mem_rvalid_i;
   logic [31:0] mem_rdata_i;

   modport slave (
      input  flush_i,
      input  if_req_i, if_addr_i,
      output if_rvalid_o, if_rdata_o, if_err_o,
      input  ls_req_i, ls_addr_i,
      output ls_rvalid_o, ls_rdata_o, ls_err_o,
      output mem_req_o, mem_addr_o,
      input  mem_ready_i, mem_rvalid_i, mem_rdata_i
   );

   modport master (
      output flush_i,
      output if_req_i, if_addr_i,
      input  if_rvalid_o, if_rdata_o, if_err_o,
      output ls_req_i, ls_addr_i,
      input  ls_rvalid_o, ls_rdata_o, ls_err_o,
      input  mem_req_o, mem_addr_o,
      output mem_ready_i, mem_rvalid_i, mem_rdata_i
   );
endinterface

// File: rtl/ptw_mem_arbiter.sv
// Round-robin arbiter sharing one memory read port between the IFU and LSU page-table walkers.
// One transaction outstanding at a time; handles sfence.vma flush and a response watchdog.
module ptw_mem_arbiter #(
   parameter int TIMEOUT_CYCLES = 1023
) (
   input  logic            clk,
   input  logic            rst,
   ptw_mem_arbiter_if.slave bus
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_REQ   = 3'd1;
   localparam logic [2:0] S_WAIT  = 3'd2;
   localparam logic [2:0] S_RESP  = 3'd3;
   localparam logic [2:0] S_DRAIN = 3'd4;

   localparam logic [9:0] TMO_LAST = 10'(TIMEOUT_CYCLES - 1);

   logic [2:0]  state;
   logic        owner;      // 0 = IFU, 1 = LSU
   logic        rr_prio;    // requester favoured on a tie
   logic [9:0]  wait_cnt;
   logic        mem_req_q;
   logic [31:0] mem_addr_q;
   logic        if_rvalid_q, ls_rvalid_q;
   logic        if_err_q, ls_err_q;
   logic [31:0] if_rdata_q, ls_rdata_q;

   logic        grant;
   logic        grant_ls;
   logic [31:0] sel_addr;
   logic        timeout_hit;
   logic        cpl_fire;
   logic        cpl_err;
   logic [31:0] cpl_data;

   always_comb begin
      grant    = (bus.if_req_i | bus.ls_req_i) & ~bus.flush_i;
      grant_ls = bus.ls_req_i & (~bus.if_req_i | rr_prio);
      sel_addr = grant_ls ? bus.ls_addr_i : bus.if_addr_i;
   end

   // wait_cnt holds the number of WAIT cycles already spent, so the watchdog
   // fires at the end of the TIMEOUT_CYCLES-th one.
   assign timeout_hit = (TIMEOUT_CYCLES != 0) && (wait_cnt == TMO_LAST);

   // A real response wins over the watchdog; a flush suppresses both.
   always_comb begin
      cpl_fire = 1'b0;
      cpl_err  = 1'b0;
      cpl_data = bus.mem_rdata_i;
      if (state == S_WAIT) begin
         if (bus.mem_rvalid_i) begin
            cpl_fire = ~bus.flush_i;
         end else if (!bus.flush_i && timeout_hit) begin
            cpl_fire = 1'b1;
            cpl_err  = 1'b1;
            cpl_data = '0;
         end
      end
   end

   // NOTE: every register, including the data holding registers, clears on the
   // asynchronous reset, and all state updates use non-blocking assignments.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= S_IDLE;
         owner       <= 1'b0;
         rr_prio     <= 1'b0;
         wait_cnt    <= '0;
         mem_req_q   <= 1'b0;
         mem_addr_q  <= '0;
         if_rvalid_q <= 1'b0;
         ls_rvalid_q <= 1'b0;
         if_err_q    <= 1'b0;
         ls_err_q    <= 1'b0;
         if_rdata_q  <= '0;
         ls_rdata_q  <= '0;
      end else begin
         if_rvalid_q <= 1'b0;
         ls_rvalid_q <= 1'b0;
         if_err_q    <= 1'b0;
         ls_err_q    <= 1'b0;

         if (cpl_fire) begin
            if (owner) begin
               ls_rvalid_q <= 1'b1;
               ls_err_q    <= cpl_err;
               ls_rdata_q  <= cpl_data;
            end else begin
               if_rvalid_q <= 1'b1;
               if_err_q    <= cpl_err;
               if_rdata_q  <= cpl_data;
            end
         end

         case (state)
            S_IDLE: begin
               if (grant) begin
                  owner      <= grant_ls;
                  mem_addr_q <= sel_addr & 32'hFFFF_FFFC;
                  mem_req_q  <= 1'b1;
                  state      <= S_REQ;
                  if (bus.if_req_i && bus.ls_req_i) rr_prio <= ~grant_ls;
               end
            end
            S_REQ: begin
               if (bus.mem_ready_i) begin
                  mem_req_q <= 1'b0;
                  wait_cnt  <= '0;
                  state     <= bus.flush_i ? S_DRAIN : S_WAIT;
               end else if (bus.flush_i) begin
                  mem_req_q <= 1'b0;
                  state     <= S_IDLE;
               end
            end
            S_WAIT: begin
               if (bus.mem_rvalid_i) begin
                  state <= bus.flush_i ? S_IDLE : S_RESP;
               end else if (bus.flush_i || timeout_hit) begin
                  // The memory still owes a response; DRAIN absorbs it.
                  state <= S_DRAIN;
               end else begin
                  wait_cnt <= wait_cnt + 10'd1;
               end
            end
            S_RESP:  state <= S_IDLE;
            S_DRAIN: if (bus.mem_rvalid_i) state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.mem_req_o   = mem_req_q;
   assign bus.mem_addr_o  = mem_addr_q;
   assign bus.if_rvalid_o = if_rvalid_q;
   assign bus.if_rdata_o  = if_rdata_q;
   assign bus.if_err_o    = if_err_q;
   assign bus.ls_rvalid_o = ls_rvalid_q;
   assign bus.ls_rdata_o  = ls_rdata_q;
   assign bus.ls_err_o    = ls_err_q;

endmodule
